// File: rtl/ghost_defs.sv
// ghost_defs
//   Shared definitions for the ghost path-finding blocks and their scheduler:
//   one-hot mode encodings, direction codes, ghost indices and a small
//   helper for sizing timers.
package ghost_defs;

   // One-hot ghost mode as seen on each ghost's 4-bit mode input.
   typedef enum logic [3:0] {
      MODE_CHASE   = 4'b1000,
      MODE_SCATTER = 4'b0100,
      MODE_FRIGHT  = 4'b0010,
      MODE_EATEN   = 4'b0001
   } mode_t;

   // Movement directions used by the path-finding blocks.
   typedef enum logic [1:0] {
      DIR_LEFT  = 2'd0,
      DIR_RIGHT = 2'd1,
      DIR_UP    = 2'd2,
      DIR_DOWN  = 2'd3
   } dir_t;

   // Ghost slots within the packed mode/rotate vectors.
   localparam int GHOST_BLINKY = 0;
   localparam int GHOST_PINKY  = 1;
   localparam int GHOST_INKY   = 2;
   localparam int GHOST_CLYDE  = 3;
   localparam int NUM_GHOSTS   = 4;

   function automatic int max_of3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/ghost_mode_fsm.sv
// ghost_mode_fsm
//   Mode and reverse-direction resolution for a single ghost. State only
//   moves on the scheduler tick, so mode/rotate are stable while update is
//   high.
// Ports:
//   clock         in  system clock
//   resetn        in  asynchronous active-low reset
//   tick          in  one-clock game tick pulse
//   global_chase  in  global phase that applies after this tick (1 = chase)
//   pellet        in  power pellet pending this tick
//   eaten         in  this ghost was caught (pending this tick)
//   home          in  this ghost reached the house (pending this tick)
//   fright_expire in  frightened timer runs out this tick
//   mode          out one-hot mode (Chase/Scatter/Frightened/Eaten)
//   rotate        out reverse-direction request, held for one tick period
module ghost_mode_fsm
   import ghost_defs::*;
(
   input  logic       clock,
   input  logic       resetn,
   input  logic       tick,
   input  logic       global_chase,
   input  logic       pellet,
   input  logic       eaten,
   input  logic       home,
   input  logic       fright_expire,
   output logic [3:0] mode,
   output logic       rotate
);

   mode_t state_reg, state_next;
   logic  rotate_reg, rotate_next;
   mode_t global_mode;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_reg  <= MODE_SCATTER;
         rotate_reg <= 1'b0;
      end else begin
         state_reg  <= state_next;
         rotate_reg <= rotate_next;
      end
   end

   always_comb begin
      global_mode = global_chase ? MODE_CHASE : MODE_SCATTER;
      state_next  = state_reg;
      rotate_next = rotate_reg;
      if (tick) begin
         // rotate lasts exactly one tick period unless re-asserted below
         rotate_next = 1'b0;
         if (state_reg == MODE_EATEN && home) begin
            state_next = global_mode;
         end else if (state_reg == MODE_FRIGHT && eaten) begin
            state_next = MODE_EATEN;
         end else if (pellet && state_reg != MODE_EATEN) begin
            // a reload while already frightened keeps the current heading
            state_next  = MODE_FRIGHT;
            rotate_next = (state_reg != MODE_FRIGHT);
         end else if (state_reg == MODE_FRIGHT && fright_expire) begin
            state_next = global_mode;
         end else if (state_reg == MODE_CHASE || state_reg == MODE_SCATTER) begin
            state_next  = global_mode;
            rotate_next = (global_mode != state_reg);
         end
      end
   end

   assign mode   = state_reg;
   assign rotate = rotate_reg;

endmodule

// File: rtl/ghost_mode_scheduler.sv
// ghost_mode_scheduler
//   Central sequencer for the four ghosts: game tick divider, update strobe,
//   scatter/chase phase timer, frightened timer, event latching and one
//   ghost_mode_fsm per ghost.
// Ports:
//   clock         in  system clock
//   resetn        in  asynchronous active-low reset
//   enable        in  game running; low freezes counters and strobes
//   pellet_eaten  in  one-clock pulse, power pellet consumed
//   ghost_eaten   in  [3:0] one-clock pulse per ghost, frightened ghost caught
//   ghost_home    in  [3:0] one-clock pulse per ghost, eaten ghost reached house
//   update        out ghost update strobe (UPDATE_HIGH clocks per tick)
//   mode          out [15:0] one-hot mode per ghost, ghost g at [4g+3:4g]
//   rotate        out [3:0] per-ghost reverse-direction request
//   fright_active out frightened timer running
//   global_chase  out global phase, 1 = chase, 0 = scatter
module ghost_mode_scheduler
   import ghost_defs::*;
#(
   parameter int TICK_DIV      = 833333,
   parameter int UPDATE_HIGH   = 4,
   parameter int SCATTER_TICKS = 420,
   parameter int CHASE_TICKS   = 1200,
   parameter int FRIGHT_TICKS  = 360,
   parameter int NUM_SCATTERS  = 4
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic        enable,
   input  logic        pellet_eaten,
   input  logic [3:0]  ghost_eaten,
   input  logic [3:0]  ghost_home,
   output logic        update,
   output logic [15:0] mode,
   output logic [3:0]  rotate,
   output logic        fright_active,
   output logic        global_chase
);

   localparam int MAX_TICKS  = max_of3(SCATTER_TICKS, CHASE_TICKS, FRIGHT_TICKS);
   localparam int TW         = $clog2(MAX_TICKS) + 1;
   localparam int PW         = $clog2(2 * NUM_SCATTERS) + 1;
   localparam int DW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int UW         = $clog2(UPDATE_HIGH + 1);
   localparam int LAST_PHASE = 2 * NUM_SCATTERS - 1;

   logic [DW-1:0] div_reg;
   logic          tick;
   logic          tick_d_reg;
   logic          update_reg;
   logic [UW-1:0] update_cnt_reg;

   logic          pellet_pend_reg;
   logic [3:0]    eaten_pend_reg;
   logic [3:0]    home_pend_reg;
   logic          pellet_ev;
   logic [3:0]    eaten_ev;
   logic [3:0]    home_ev;

   logic [PW-1:0] phase_reg, phase_next;
   logic [TW-1:0] phase_tmr_reg, phase_tmr_next;
   logic [TW-1:0] phase_limit;
   logic [TW-1:0] fright_tmr_reg, fright_tmr_next;
   logic          fright_active_reg, fright_active_next;
   logic          fright_expire;

   // tick is the clock on which the divider wraps; all mode state moves here
   assign tick = enable && (div_reg == DW'(TICK_DIV - 1));

   // Events arriving on the tick clock itself are folded in directly so
   // nothing is lost between latch and consume.
   assign pellet_ev = pellet_pend_reg | pellet_eaten;
   assign eaten_ev  = eaten_pend_reg | ghost_eaten;
   assign home_ev   = home_pend_reg | ghost_home;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         div_reg         <= '0;
         tick_d_reg      <= 1'b0;
         update_reg      <= 1'b0;
         update_cnt_reg  <= '0;
         pellet_pend_reg <= 1'b0;
         eaten_pend_reg  <= '0;
         home_pend_reg   <= '0;
      end else begin
         if (enable) begin
            div_reg <= tick ? '0 : div_reg + DW'(1);
         end
         tick_d_reg <= tick;

         // update rises one clock after tick so mode/rotate have already
         // settled; an in-flight pulse always finishes even if disabled
         if (update_reg) begin
            if (update_cnt_reg == UW'(UPDATE_HIGH - 1)) begin
               update_reg     <= 1'b0;
               update_cnt_reg <= '0;
            end else begin
               update_cnt_reg <= update_cnt_reg + UW'(1);
            end
         end else if (tick_d_reg && enable) begin
            update_reg     <= 1'b1;
            update_cnt_reg <= '0;
         end

         if (tick) begin
            pellet_pend_reg <= 1'b0;
            eaten_pend_reg  <= '0;
            home_pend_reg   <= '0;
         end else begin
            pellet_pend_reg <= pellet_ev;
            eaten_pend_reg  <= eaten_ev;
            home_pend_reg   <= home_ev;
         end
      end
   end

   // Frightened timer: a pellet (re)loads it, otherwise it counts down.
   always_comb begin
      fright_tmr_next    = fright_tmr_reg;
      fright_active_next = fright_active_reg;
      fright_expire      = 1'b0;
      if (tick) begin
         if (pellet_ev) begin
            fright_tmr_next    = TW'(FRIGHT_TICKS);
            fright_active_next = 1'b1;
         end else if (fright_tmr_reg != '0) begin
            fright_tmr_next = fright_tmr_reg - TW'(1);
            if (fright_tmr_reg == TW'(1)) begin
               fright_active_next = 1'b0;
               fright_expire      = 1'b1;
            end
         end
      end
   end

   // Phase timer is paused for every tick that ends with fright running,
   // and resumes on the tick on which fright expires.
   assign phase_limit = phase_reg[0] ? TW'(CHASE_TICKS) : TW'(SCATTER_TICKS);

   always_comb begin
      phase_next     = phase_reg;
      phase_tmr_next = phase_tmr_reg;
      if (tick && !fright_active_next && phase_reg != PW'(LAST_PHASE)) begin
         if (phase_tmr_reg + TW'(1) == phase_limit) begin
            phase_tmr_next = '0;
            phase_next     = phase_reg + PW'(1);
         end else begin
            phase_tmr_next = phase_tmr_reg + TW'(1);
         end
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         phase_reg         <= '0;
         phase_tmr_reg     <= '0;
         fright_tmr_reg    <= '0;
         fright_active_reg <= 1'b0;
      end else begin
         phase_reg         <= phase_next;
         phase_tmr_reg     <= phase_tmr_next;
         fright_tmr_reg    <= fright_tmr_next;
         fright_active_reg <= fright_active_next;
      end
   end

   // Ghosts see the phase that results from this tick so a phase change and
   // the matching rotate land on the same update pulse.
   generate
      for (genvar gi = 0; gi < NUM_GHOSTS; gi++) begin : g_ghost
         ghost_mode_fsm u_fsm (
            .clock         (clock),
            .resetn        (resetn),
            .tick          (tick),
            .global_chase  (phase_next[0]),
            .pellet        (pellet_ev),
            .eaten         (eaten_ev[gi]),
            .home          (home_ev[gi]),
            .fright_expire (fright_expire),
            .mode          (mode[4*gi +: 4]),
            .rotate        (rotate[gi])
         );
      end
   endgenerate

   assign update        = update_reg;
   assign fright_active = fright_active_reg;
   assign global_chase  = phase_reg[0];

endmodule

// File: tb/tb_ghost_mode_scheduler.sv
module tb_ghost_mode_scheduler;

   logic        clock = 1'b0;
   logic        resetn = 1'b0;
   logic        enable = 1'b0;
   logic        pellet_eaten = 1'b0;
   logic [3:0]  ghost_eaten = 4'h0;
   logic [3:0]  ghost_home = 4'h0;
   logic        update;
   logic [15:0] mode;
   logic [3:0]  rotate;
   logic        fright_active;
   logic        global_chase;

   int n_checks = 0;
   int n_fail   = 0;

   ghost_mode_scheduler #(
      .TICK_DIV      (10),
      .UPDATE_HIGH   (3),
      .SCATTER_TICKS (5),
      .CHASE_TICKS   (8),
      .FRIGHT_TICKS  (4),
      .NUM_SCATTERS  (2)
   ) dut (
      .clock         (clock),
      .resetn        (resetn),
      .enable        (enable),
      .pellet_eaten  (pellet_eaten),
      .ghost_eaten   (ghost_eaten),
      .ghost_home    (ghost_home),
      .update        (update),
      .mode          (mode),
      .rotate        (rotate),
      .fright_active (fright_active),
      .global_chase  (global_chase)
   );

   always #5 clock = ~clock;

   task automatic do_reset();
      resetn       = 1'b0;
      enable       = 1'b0;
      pellet_eaten = 1'b0;
      ghost_eaten  = 4'h0;
      ghost_home   = 4'h0;
      repeat (3) @(posedge clock);
      #1;
      resetn = 1'b1;
      enable = 1'b1;
   endtask

   // One-clock event pulse on the inputs.
   task automatic pulse_events(input logic p, input logic [3:0] ge, input logic [3:0] gh);
      pellet_eaten = p;
      ghost_eaten  = ge;
      ghost_home   = gh;
      @(posedge clock);
      #1;
      pellet_eaten = 1'b0;
      ghost_eaten  = 4'h0;
      ghost_home   = 4'h0;
   endtask

   // Advance to the next rising edge of update (bounded) and log it.
   task automatic wait_rise(input string tag);
      logic prev;
      bit   got;
      prev = update;
      got  = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clock);
         #1;
         if (update === 1'b1 && prev === 1'b0) begin
            got = 1;
            break;
         end
         prev = update;
      end
      n_checks++;
      if (!got) begin
         n_fail++;
         $display("FAIL %s update_rise: got no rise in 40 clocks, expected a rise", tag);
      end else begin
         $display("%s: update mode=%h rotate=%h fright=%b chase=%b",
                  tag, mode, rotate, fright_active, global_chase);
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (update !== 1'b0) begin n_fail++; $display("FAIL reset_update: got %b expected 0", update); end
      n_checks++;
      if (mode !== 16'h4444) begin n_fail++; $display("FAIL reset_mode: got %h expected 4444", mode); end
      n_checks++;
      if (rotate !== 4'h0) begin n_fail++; $display("FAIL reset_rotate: got %h expected 0", rotate); end
      n_checks++;
      if (fright_active !== 1'b0) begin n_fail++; $display("FAIL reset_fright: got %b expected 0", fright_active); end
      n_checks++;
      if (global_chase !== 1'b0) begin n_fail++; $display("FAIL reset_chase: got %b expected 0", global_chase); end
   endtask

   task automatic test_update_timing();
      int  hi;
      int  per;
      bit  seen_low;
      do_reset();
      wait_rise("timing");
      hi = 1; per = 0; seen_low = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clock);
         #1;
         per++;
         if (update !== 1'b1) seen_low = 1;
         else if (seen_low) break;
         else hi++;
      end
      n_checks++;
      if (hi != 3) begin n_fail++; $display("FAIL update_width: got %0d clocks high expected 3", hi); end
      n_checks++;
      if (per != 10) begin n_fail++; $display("FAIL update_period: got %0d clocks expected 10", per); end
   endtask

   task automatic test_phases();
      logic [15:0] em;
      logic [3:0]  er;
      do_reset();
      for (int k = 1; k <= 20; k++) begin
         wait_rise($sformatf("phase k=%0d", k));
         em = (k < 5) ? 16'h4444 : (k < 13) ? 16'h8888 : (k < 18) ? 16'h4444 : 16'h8888;
         er = (k == 5 || k == 13 || k == 18) ? 4'hF : 4'h0;
         n_checks++;
         if (mode !== em) begin n_fail++; $display("FAIL phase_mode k=%0d: got %h expected %h", k, mode, em); end
         n_checks++;
         if (rotate !== er) begin n_fail++; $display("FAIL phase_rotate k=%0d: got %h expected %h", k, rotate, er); end
         n_checks++;
         if (global_chase !== em[3]) begin n_fail++; $display("FAIL phase_chase k=%0d: got %b expected %b", k, global_chase, em[3]); end
      end
      for (int k = 21; k <= 120; k++) begin
         wait_rise($sformatf("final k=%0d", k));
         n_checks++;
         if (mode !== 16'h8888 || rotate !== 4'h0) begin
            n_fail++;
            $display("FAIL final_chase k=%0d: got mode %h rotate %h expected 8888/0", k, mode, rotate);
         end
      end
   endtask

   task automatic test_pellet_scatter();
      do_reset();
      wait_rise("pel k=1");
      wait_rise("pel k=2");
      pulse_events(1'b1, 4'h0, 4'h0);
      wait_rise("pel k=3");
      n_checks++;
      if (mode !== 16'h2222 || rotate !== 4'hF || fright_active !== 1'b1) begin
         n_fail++;
         $display("FAIL pellet_enter: got mode %h rot %h fr %b expected 2222/F/1", mode, rotate, fright_active);
      end
      wait_rise("pel k=4");
      n_checks++;
      if (mode !== 16'h2222 || rotate !== 4'h0) begin
         n_fail++;
         $display("FAIL pellet_hold: got mode %h rot %h expected 2222/0", mode, rotate);
      end
      wait_rise("pel k=5");
      wait_rise("pel k=6");
      wait_rise("pel k=7");
      n_checks++;
      if (mode !== 16'h4444 || rotate !== 4'h0 || fright_active !== 1'b0) begin
         n_fail++;
         $display("FAIL pellet_expire: got mode %h rot %h fr %b expected 4444/0/0", mode, rotate, fright_active);
      end
      wait_rise("pel k=8");
      n_checks++;
      if (mode !== 16'h4444) begin n_fail++; $display("FAIL pellet_resume8: got %h expected 4444", mode); end
      wait_rise("pel k=9");
      n_checks++;
      if (mode !== 16'h8888 || rotate !== 4'hF) begin
         n_fail++;
         $display("FAIL pellet_resume9: got mode %h rot %h expected 8888/F", mode, rotate);
      end
   endtask

   task automatic test_ghost_eaten();
      do_reset();
      wait_rise("eat k=1");
      pulse_events(1'b1, 4'h0, 4'h0);
      wait_rise("eat k=2");
      pulse_events(1'b0, 4'b0010, 4'h0);
      wait_rise("eat k=3");
      n_checks++;
      if (mode !== 16'h2212 || rotate !== 4'h0) begin
         n_fail++;
         $display("FAIL eaten_enter: got mode %h rot %h expected 2212/0", mode, rotate);
      end
      wait_rise("eat k=4");
      wait_rise("eat k=5");
      wait_rise("eat k=6");
      n_checks++;
      if (mode !== 16'h4414 || fright_active !== 1'b0 || rotate !== 4'h0) begin
         n_fail++;
         $display("FAIL eaten_persist: got mode %h fr %b rot %h expected 4414/0/0", mode, fright_active, rotate);
      end
      pulse_events(1'b0, 4'h0, 4'b0010);
      wait_rise("eat k=7");
      n_checks++;
      if (mode !== 16'h4444 || rotate !== 4'h0) begin
         n_fail++;
         $display("FAIL eaten_home: got mode %h rot %h expected 4444/0", mode, rotate);
      end
      // events for ghosts not in the matching state are ignored
      pulse_events(1'b0, 4'b0100, 4'b1000);
      wait_rise("eat k=8");
      n_checks++;
      if (mode !== 16'h4444 || rotate !== 4'h0) begin
         n_fail++;
         $display("FAIL eaten_ignore: got mode %h rot %h expected 4444/0", mode, rotate);
      end
   endtask

   task automatic test_reload();
      do_reset();
      wait_rise("rel k=1");
      pulse_events(1'b1, 4'h0, 4'h0);
      wait_rise("rel k=2");
      wait_rise("rel k=3");
      pulse_events(1'b1, 4'h0, 4'h0);
      wait_rise("rel k=4");
      n_checks++;
      if (mode !== 16'h2222 || rotate !== 4'h0) begin
         n_fail++;
         $display("FAIL reload_norot: got mode %h rot %h expected 2222/0", mode, rotate);
      end
      wait_rise("rel k=5");
      wait_rise("rel k=6");
      wait_rise("rel k=7");
      n_checks++;
      if (mode !== 16'h2222 || fright_active !== 1'b1) begin
         n_fail++;
         $display("FAIL reload_still: got mode %h fr %b expected 2222/1", mode, fright_active);
      end
      wait_rise("rel k=8");
      n_checks++;
      if (mode !== 16'h4444 || fright_active !== 1'b0 || rotate !== 4'h0) begin
         n_fail++;
         $display("FAIL reload_end: got mode %h fr %b rot %h expected 4444/0/0", mode, fright_active, rotate);
      end
   endtask

   task automatic test_same_clock();
      do_reset();
      wait_rise("same k=1");
      pulse_events(1'b1, 4'h0, 4'h0);
      wait_rise("same k=2");
      pulse_events(1'b1, 4'b0001, 4'h0);
      wait_rise("same k=3");
      n_checks++;
      if (mode !== 16'h2221 || rotate !== 4'h0) begin
         n_fail++;
         $display("FAIL same_enter: got mode %h rot %h expected 2221/0", mode, rotate);
      end
      wait_rise("same k=4");
      wait_rise("same k=5");
      wait_rise("same k=6");
      n_checks++;
      if (mode !== 16'h2221 || fright_active !== 1'b1) begin
         n_fail++;
         $display("FAIL same_reload: got mode %h fr %b expected 2221/1", mode, fright_active);
      end
      wait_rise("same k=7");
      n_checks++;
      if (mode !== 16'h4441 || fright_active !== 1'b0) begin
         n_fail++;
         $display("FAIL same_expire: got mode %h fr %b expected 4441/0", mode, fright_active);
      end
   endtask

   task automatic test_enable();
      int hi;
      int cnt;
      do_reset();
      wait_rise("en k=1");
      enable = 1'b0;
      hi = 1;
      for (int i = 0; i < 50; i++) begin
         if (i == 10) pellet_eaten = 1'b1;
         if (i == 11) pellet_eaten = 1'b0;
         @(posedge clock);
         #1;
         if (update === 1'b1) hi++;
      end
      pellet_eaten = 1'b0;
      n_checks++;
      if (hi != 3) begin n_fail++; $display("FAIL enable_update: got %0d clocks high expected 3", hi); end
      n_checks++;
      if (fright_active !== 1'b0 || mode !== 16'h4444) begin
         n_fail++;
         $display("FAIL enable_frozen: got mode %h fr %b expected 4444/0", mode, fright_active);
      end
      enable = 1'b1;
      cnt = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clock);
         #1;
         cnt++;
         if (update === 1'b1) break;
      end
      n_checks++;
      if (cnt != 10) begin n_fail++; $display("FAIL enable_resume: got rise after %0d clocks expected 10", cnt); end
      n_checks++;
      if (mode !== 16'h2222 || rotate !== 4'hF || fright_active !== 1'b1) begin
         n_fail++;
         $display("FAIL enable_event: got mode %h rot %h fr %b expected 2222/F/1", mode, rotate, fright_active);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      wait_rise("rst k=1");
      pulse_events(1'b1, 4'h0, 4'h0);
      wait_rise("rst k=2");
      #2;
      resetn = 1'b0;
      #1;
      n_checks++;
      if (update !== 1'b0 || mode !== 16'h4444 || rotate !== 4'h0 || fright_active !== 1'b0 || global_chase !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_async: got upd %b mode %h rot %h fr %b ch %b expected 0/4444/0/0/0",
                  update, mode, rotate, fright_active, global_chase);
      end
      repeat (2) @(posedge clock);
      #1;
      resetn = 1'b1;
      wait_rise("rst k=1b");
      n_checks++;
      if (mode !== 16'h4444 || rotate !== 4'h0 || fright_active !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_clean: got mode %h rot %h fr %b expected 4444/0/0", mode, rotate, fright_active);
      end
   endtask

   initial begin
      test_reset();
      test_update_timing();
      test_phases();
      test_pellet_scatter();
      test_ghost_eaten();
      test_reload();
      test_same_clock();
      test_enable();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
